// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with next-PC select, sync-read inst SRAM interface and stall buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int          FS_WD    = 65,
  parameter int          BR_WD    = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ds_allowin,
  input  logic [BR_WD-1:0] br_bus,
  input  logic             ws_flush,
  input  logic [31:0]      ws_flush_pc,
  output logic             fs_to_ds_valid,
  output logic [FS_WD-1:0] fs_to_ds_bus,
  output logic             inst_sram_en,
  output logic [3:0]       inst_sram_wen,
  output logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata
);
  logic        to_fs_valid_q;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_ex_q, fs_ex_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        fs_allowin;
  logic        stall_cap;
  logic [31:0] inst;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  always_comb begin
    nextpc           = ws_flush ? ws_flush_pc : (br_taken && fs_valid_q) ? br_target : fs_pc_q + 32'd4;
    fs_allowin       = !fs_valid_q || ds_allowin || ws_flush;
    inst_sram_en     = to_fs_valid_q && fs_allowin;
    stall_cap        = fs_valid_q && !ds_allowin && !inst_buf_valid_q && !ws_flush;
    fs_valid_d       = inst_sram_en ? 1'b1 : fs_valid_q;
    fs_pc_d          = inst_sram_en ? nextpc : fs_pc_q;
    fs_ex_d          = inst_sram_en ? (nextpc[1:0] != 2'b00) : fs_ex_q;
    // A flush clears the buffer even if no request can issue this cycle.
    inst_buf_valid_d = (inst_sram_en || ws_flush) ? 1'b0 : stall_cap ? 1'b1 : inst_buf_valid_q;
    inst_buf_d       = stall_cap ? inst_sram_rdata : inst_buf_q;
    inst             = fs_ex_q ? 32'h0 : inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid_q    <= 1'b0;
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      fs_ex_q          <= 1'b0;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
    end else begin
      to_fs_valid_q    <= 1'b1;
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      fs_ex_q          <= fs_ex_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

  assign fs_to_ds_valid  = fs_valid_q && !ws_flush;
  assign fs_to_ds_bus    = {fs_ex_q, inst, fs_pc_q};
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = {nextpc[31:2], 2'b00};
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage; the SRAM model returns word address + 1 as data.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        ws_flush;
  logic [31:0] ws_flush_pc;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        scramble = 1'b0;
  logic [64:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  if_stage dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // scramble perturbs the held read data so a missing stall buffer shows up
  always @(posedge clk)
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr + 32'd1;
    else if (scramble) inst_sram_rdata <= inst_sram_rdata ^ 32'h5a5a0000;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] eb(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) ? {1'b1, 32'h0, pc} : {1'b0, {pc[31:2], 2'b00} + 32'd1, pc};
  endfunction

  task automatic cyc(input logic allow, input logic bt, input logic [31:0] bta,
                     input logic fl, input logic [31:0] flpc);
    @(negedge clk);
    ds_allowin  = allow;
    br_bus      = {bt, bta};
    ws_flush    = fl;
    ws_flush_pc = flpc;
    #1;
    if (fs_to_ds_valid && ds_allowin) begin
      if (exp_q.size() == 0) chk("extra_xfer", 65'(exp_q.size()), 65'd1);
      else chk("bus", fs_to_ds_bus, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; ds_allowin = 1'b1; br_bus = '0; ws_flush = 1'b0; ws_flush_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("rst_en", 65'(inst_sram_en), 65'd0);
    chk("rst_addr", 65'(inst_sram_addr), 65'h0bfc00000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("a_en", 65'(inst_sram_en), 65'd0);
    cyc(1, 0, 0, 0, 0);
    chk("b_en", 65'(inst_sram_en), 65'd1);
    chk("b_addr", 65'(inst_sram_addr), 65'h0bfc00000);
    chk("wen", 65'(inst_sram_wen), 65'd0);
    chk("wdata", 65'(inst_sram_wdata), 65'd0);
    // T1/T2
    exp_q.push_back(eb(32'hbfc00000));
    exp_q.push_back(eb(32'hbfc00004));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2_en", 65'(inst_sram_en), 65'd0);
      chk("t2_valid", 65'(fs_to_ds_valid), 65'd1);
      chk("t2_bus", fs_to_ds_bus, eb(32'hbfc00008));
      if (i == 0) scramble = 1'b1;
    end
    scramble = 1'b0;
    exp_q.push_back(eb(32'hbfc00008));
    exp_q.push_back(eb(32'hbfc0000c));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // T3: delay slot 0x10 leaves IF on the redirect edge
    exp_q.push_back(eb(32'hbfc00010));
    exp_q.push_back(eb(32'hbfc00100));
    cyc(1, 1, 32'hbfc00100, 0, 0);
    chk("t3_addr", 65'(inst_sram_addr), 65'h0bfc00100);
    // T4: misaligned target
    cyc(1, 1, 32'hbfc00102, 0, 0);
    exp_q.push_back(eb(32'hbfc00102));
    exp_q.push_back(eb(32'hbfc00106));
    cyc(1, 0, 0, 0, 0);
    chk("t4_addr", 65'(inst_sram_addr), 65'h0bfc00104);
    cyc(1, 0, 0, 0, 0);
    // T5: flush beats stall and branch
    cyc(0, 1, 32'hbfc00200, 1, 32'hbfc00380);
    chk("t5_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("t5_en", 65'(inst_sram_en), 65'd1);
    chk("t5_addr", 65'(inst_sram_addr), 65'h0bfc00380);
    exp_q.push_back(eb(32'hbfc00380));
    exp_q.push_back(eb(32'hbfc00384));
    exp_q.push_back(eb(32'hbfc00388));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // T6: asynchronous reset between edges
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("t6_en", 65'(inst_sram_en), 65'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("t6_a_en", 65'(inst_sram_en), 65'd0);
    cyc(1, 0, 0, 0, 0);
    chk("t6_b_en", 65'(inst_sram_en), 65'd1);
    chk("t6_b_addr", 65'(inst_sram_addr), 65'h0bfc00000);
    exp_q.push_back(eb(32'hbfc00000));
    exp_q.push_back(eb(32'hbfc00004));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("drain", 65'(exp_q.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
